// File: rtl/cache_arb_pkg.sv
// Shared types and helpers for the cache/main-memory arbiter.
// Holds the arbiter state encoding and the counter width helper.
package cache_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      D_WRITE = 2'd1,
      D_FILL  = 2'd2,
      I_FILL  = 2'd3
   } arb_state_t;

   localparam int DEF_WORDS = 8;

   // Bits needed to index WORDS words; never narrower than one bit.
   function automatic int cnt_w(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/cache_mem_arbiter_blk_word_counter.sv
// Word index counter for block fills: clear, increment enable, last flag.
// Saturates at WORDS-1 so an extra increment never wraps back to word 0.
module blk_word_counter
   import cache_arb_pkg::*;
#(
   parameter int WORDS = DEF_WORDS
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clr,
   input  logic                      inc,
   output logic [cnt_w(WORDS)-1:0]   count,
   output logic                      last
);

   localparam int CW = cnt_w(WORDS);
   localparam logic [CW-1:0] LAST_VAL = CW'(WORDS - 1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !last) begin
         count <= count + 1'b1;
      end
   end

   assign last = (count == LAST_VAL);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates main memory between I-cache fills, D-cache fills and write-through
// stores; sequences block reads, routes returned words and drives pipeline stalls.
module cache_mem_arbiter
   import cache_arb_pkg::*;
#(
   parameter int MEM_LAT = 4,
   parameter int WORDS   = DEF_WORDS,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_miss,
   input  logic [ADDR_W-1:0]         i_miss_addr,
   input  logic                      d_miss,
   input  logic [ADDR_W-1:0]         d_miss_addr,
   input  logic                      d_wr_req,
   input  logic [ADDR_W-1:0]         d_wr_addr,
   input  logic [DATA_W-1:0]         d_wr_data,
   output logic                      mem_en,
   output logic                      mem_wr,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata,
   input  logic                      mem_data_valid,
   output logic [DATA_W-1:0]         fill_data,
   output logic [cnt_w(WORDS)-1:0]   fill_word,
   output logic                      i_fill_we,
   output logic                      d_fill_we,
   output logic                      i_fill_done,
   output logic                      d_fill_done,
   output logic                      d_wr_done,
   output logic                      i_stall,
   output logic                      d_cache_miss
);

   localparam int CW = cnt_w(WORDS);
   localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(WORDS * 2 - 1);

   if (MEM_LAT < 1 || WORDS < 2 || (WORDS & (WORDS - 1)) != 0) begin : g_param_check
      $error("cache_mem_arbiter: MEM_LAT must be >= 1 and WORDS a power of two >= 2");
   end

   arb_state_t        state, state_nxt;
   logic [ADDR_W-1:0] base_addr;
   logic              issue_active;
   logic [CW-1:0]     issue_cnt, ret_cnt;
   logic              issue_last, ret_last;
   logic              in_fill, ret_hit;

   assign in_fill = (state == D_FILL) || (state == I_FILL);
   assign ret_hit = in_fill && mem_data_valid;

   // Requests are only looked at in IDLE; a grant runs to completion.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (d_wr_req)    state_nxt = D_WRITE;
            else if (d_miss) state_nxt = D_FILL;
            else if (i_miss) state_nxt = I_FILL;
         end
         D_WRITE: state_nxt = IDLE;
         default: if (ret_hit && ret_last) state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         base_addr    <= '0;
         issue_active <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE) begin
            issue_active <= (state_nxt == D_FILL) || (state_nxt == I_FILL);
            base_addr    <= (d_miss ? d_miss_addr : i_miss_addr) & ~BLK_MASK;
         end else if (issue_active && issue_last) begin
            issue_active <= 1'b0;
         end
      end
   end

   // Both counters clear on the way back to IDLE so fill_word reads 0 there.
   blk_word_counter #(.WORDS(WORDS)) u_issue_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state_nxt == IDLE),
      .inc   (in_fill && issue_active),
      .count (issue_cnt),
      .last  (issue_last)
   );

   blk_word_counter #(.WORDS(WORDS)) u_ret_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state_nxt == IDLE),
      .inc   (ret_hit),
      .count (ret_cnt),
      .last  (ret_last)
   );

   always_comb begin
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (state == D_WRITE) begin
         mem_en    = 1'b1;
         mem_wr    = 1'b1;
         mem_addr  = d_wr_addr;
         mem_wdata = d_wr_data;
      end else if (in_fill && issue_active) begin
         mem_en   = 1'b1;
         mem_addr = base_addr + (ADDR_W'(issue_cnt) << 1);
      end
   end

   assign fill_data   = mem_rdata;
   assign fill_word   = ret_cnt;
   assign i_fill_we   = (state == I_FILL) && mem_data_valid;
   assign d_fill_we   = (state == D_FILL) && mem_data_valid;
   assign i_fill_done = i_fill_we && ret_last;
   assign d_fill_done = d_fill_we && ret_last;
   assign d_wr_done   = (state == D_WRITE);

   // Stalls are combinational so the pipeline moves in the completion cycle.
   assign i_stall      = i_miss & ~i_fill_done;
   assign d_cache_miss = (d_miss & ~d_fill_done) | (d_wr_req & ~d_wr_done);

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single multi-cycle main memory between the I-cache and D-cache miss paths of the pipelined core. It grants one requester at a time, sequences 8-word block fills and single-word write-through stores, and routes returned words into the granted cache. It also produces the stall and d_cache_miss signals that freeze the fetch stage and the EX/M/WB pipeline registers.

## Interface
Parameters:
- MEM_LAT, 4: cycles from mem_en read issue to mem_data_valid.
- WORDS, 8: words per cache block; a power of two.
- ADDR_W, 16: byte-address width.
- DATA_W, 16: word width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low. Also drives main-memory reset.
- i_miss  in  1  I-cache miss request; level, held until i_fill_done.
- i_miss_addr  in  ADDR_W  I-side miss byte address.
- d_miss  in  1  D-cache miss request; level.
- d_miss_addr  in  ADDR_W  D-side miss byte address.
- d_wr_req  in  1  write-through store request; level.
- d_wr_addr  in  ADDR_W  store byte address.
- d_wr_data  in  DATA_W  store data.
- mem_en  out  1  memory access strobe.
- mem_wr  out  1  1 means write, 0 means read; valid with mem_en.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_data_valid  in  1  mem_rdata valid this cycle.
- fill_data  out  DATA_W  mem_rdata passed through.
- fill_word  out  log2(WORDS)  word index within the block being filled.
- i_fill_we / d_fill_we  out  1  cache data-array write enables.
- i_fill_done / d_fill_done  out  1  one-cycle pulse on the last fill word; the cache writes its tag/valid bit.
- d_wr_done  out  1  one-cycle pulse when the store is accepted.
- i_stall  out  1  fetch stall.
- d_cache_miss  out  1  freezes the EX/M/WB registers.

## Operation
- FSM states: IDLE, D_WRITE, D_FILL, I_FILL.
- Requests are sampled only in IDLE. Priority is d_wr_req > d_miss > i_miss.
- A grant is held until completion. Deasserting the request mid-operation does not abort it: the fill completes and the cache still receives the block.
- D_WRITE: for one cycle, mem_en=1, mem_wr=1, mem_addr=d_wr_addr, mem_wdata=d_wr_data, d_wr_done=1. Next state is IDLE.
- D_FILL / I_FILL:
  - Block base is addr with the low log2(WORDS*2) bits cleared.
  - Issue counter k runs 0..WORDS-1. Each cycle drive mem_en=1, mem_wr=0, mem_addr=base+2k.
  - After k=WORDS-1, mem_en=0.
  - Return counter r increments on each mem_data_valid. fill_word=r, and the granted side's fill_we=mem_data_valid.
  - When r=WORDS-1 and valid, pulse the granted side's fill_done and go to IDLE.
- mem_data_valid outside a fill state is ignored.
- i_stall = i_miss & ~i_fill_done.
- d_cache_miss = (d_miss & ~d_fill_done) | (d_wr_req & ~d_wr_done).
- Both stall outputs are combinational, so the pipeline releases in the completion cycle.
- Counters are log2(WORDS) bits wide, with no wrap beyond WORDS-1. Address add is modulo 2^ADDR_W.

## Timing
- Reset values: state IDLE, counters 0, all outputs 0 except the combinational stalls, which follow their inputs.
- Reset mid-operation: abort immediately to IDLE. Memory is reset by the same rst_n, so no stale returns can arrive.
- Request seen in IDLE at cycle t:
  - First mem_en at t+1.
  - Word k read data returns at t+1+k+MEM_LAT.
  - fill_done at t+WORDS+MEM_LAT.
  - IDLE at t+WORDS+MEM_LAT+1.
- Store: d_wr_done at t+1; IDLE at t+2.
- Back-to-back grants have exactly one IDLE cycle between them.
- Simultaneous d_wr_req, d_miss and i_miss: the store is served first, then the D fill, then the I fill. The I side waits for both.

## Structure
- Package cache_arb_pkg holds:
  - the state enum typedef (IDLE, D_WRITE, D_FILL, I_FILL);
  - a default WORDS constant;
  - a log2 helper for fill_word width.
- One sub-module, blk_word_counter: a log2(WORDS)-bit counter with clear, increment enable and a last flag. It is instantiated twice, as the issue and return counters.

## Test plan
- i_miss=1 at 0x1236 only. Reads issue at 0x1230..0x123E on 8 consecutive cycles. Eight i_fill_we arrive with fill_word 0..7, i_fill_done at cycle t+12, i_stall drops the same cycle.
- d_miss and i_miss asserted together. The D fill completes first (d_fill_done at t+12), IDLE at t+13, I-fill reads start at t+14 with i_stall high throughout.
- d_wr_req, addr 0x00A4, data 0xBEEF. At t+1: mem_en=1, mem_wr=1, address 0x00A4, data 0xBEEF, d_wr_done=1, d_cache_miss=0 the same cycle.
- d_miss deasserted at t+3 during a fill. All 8 words are still written, d_fill_done pulses at t+12, no abort.
- rst_n=0 at t+5 of a fill. Next cycle IDLE, all outputs 0, and a fresh request restarts at word 0.
- Spurious mem_data_valid in IDLE. No fill_we and no state change.
